pe_cmd_issuer: RTL and testbench

Command-side driver for the PE arithmetic core. Accepts arithmetic commands (func, two operands, tag) over a valid/ready interface and buffers them in a small FIFO. It encodes each command into the PE's 32-bit opcode word, drives the PE operand ports for one cycle, captures the registered PE result after a fixed latency, and returns it with the original tag over a valid/ready response interface. It sits between the PE array scheduler and one PE instance.

---
 rtl/pe_pkg.sv | 44 ++++
 rtl/pe_cmd_fifo.sv | 51 +++++
 rtl/pe_cmd_issuer.sv | 150 +++++++++++++++
 tb/tb_pe_cmd_issuer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// ============================================================================
// pe_pkg : shared opcode fields, func codes and FSM state type for the PE path
// Rev 1.0
// ============================================================================
`default_nettype none

package pe_pkg;

  localparam logic [6:0] OPC_ARITH = 7'b0000001;
  localparam logic [6:0] OPC_FPU   = 7'b0000010;
  localparam logic [6:0] OPC_COMP  = 7'b0010000;

  localparam int FUNC_W = 5;
  localparam logic [FUNC_W-1:0] FN_ADD = 5'd1;
  localparam logic [FUNC_W-1:0] FN_SUB = 5'd2;
  localparam logic [FUNC_W-1:0] FN_MUL = 5'd3;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 25;
  localparam int FUNC_MSB = 24;
  localparam int FUNC_LSB = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic func_legal(input logic [FUNC_W-1:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_MUL);
  endfunction

  function automatic logic [31:0] encode_opcode(input logic [FUNC_W-1:0] f);
    logic [31:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB]   = OPC_ARITH;
    w[FUNC_MSB:FUNC_LSB] = f;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_cmd_fifo.sv
// ============================================================================
// pe_cmd_fifo : synchronous FIFO with fall-through head and full/empty flags
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/pe_cmd_issuer.sv
// ============================================================================
// pe_cmd_issuer : buffers arithmetic commands, issues them to one PE and
//                 returns tagged results in order
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_cmd_issuer
  import pe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_func,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [31:0]       pe_opcode,
  output logic [DATA_W-1:0] pe_op1,
  output logic [DATA_W-1:0] pe_op2,
  input  logic [DATA_W-1:0] pe_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  localparam int ENT_W = FUNC_W + 2*DATA_W + TAG_W;
  localparam int CNT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  state_t             state;
  state_t             next_state;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENT_W-1:0]   head;
  logic [FUNC_W-1:0]  head_func;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic [TAG_W-1:0]   head_tag;
  logic [CNT_W-1:0]   cnt;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign {head_func, head_a, head_b, head_tag} = head;

  pe_cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cmd_func, cmd_a, cmd_b, cmd_tag}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // IDLE and a completed RESP handshake share the same dispatch decision.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = func_legal(head_func) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (cnt == '0)
          next_state = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = func_legal(head_func) ? ST_ISSUE : ST_RESP;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_opcode <= '0;
      pe_op1    <= '0;
      pe_op2    <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (pop) begin
        rsp_tag <= head_tag;
        if (func_legal(head_func)) begin
          pe_opcode <= encode_opcode(head_func);
          pe_op1    <= head_a;
          pe_op2    <= head_b;
        end else begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state == ST_ISSUE) begin
        pe_opcode <= '0;
        cnt       <= CNT_W'(PE_LAT - 1);
      end
      if (state == ST_WAIT) begin
        if (cnt == '0) begin
          rsp_data <= pe_result;
          rsp_err  <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    rsp_valid = (state == ST_RESP);
    busy      = (state != ST_IDLE) || !empty;
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_cmd_issuer.sv
// ============================================================================
// tb_pe_cmd_issuer : directed plus randomized checks against a queue-based
//                    reference model and a single-register PE model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pe_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_func;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic [31:0] pe_opcode, pe_op1, pe_op2;
  logic [31:0] pe_result = 32'd0;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  typedef struct {
    logic [4:0]  func;
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] prev_op = 32'd0;

  always #5 clk = ~clk;

  pe_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .pe_opcode(pe_opcode), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_result(pe_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic legal(input logic [4:0] f);
    return f >= 5'd1 && f <= 5'd3;
  endfunction

  function automatic logic [31:0] arith(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // One-stage registered PE: result valid the cycle after it samples the opcode.
  always @(posedge clk) begin
    if (pe_opcode[31:25] == 7'b0000001)
      pe_result <= arith(pe_opcode[24:20], pe_op1, pe_op2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pe_opcode !== 32'd0) begin
        chk("op_single_cycle", prev_op, 32'd0);
        if (expq.size() == 0)
          chk("op_no_cmd", pe_opcode, 32'd0);
        else
          chk("op_encode", pe_opcode,
              legal(expq[0].func) ? {7'b0000001, expq[0].func, 20'd0} : 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
    prev_op = pe_opcode;
  end

  // Called at posedge+#1; returns at posedge+#1 just after the push edge.
  task automatic push_cmd(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t, input bit rnd);
    int w = 0;
    exp_t e;
    cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b; cmd_tag = t;
    while (!cmd_ready && w < 200) begin
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1; w++;
    end
    chk("push_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    e.func = f; e.tag = t; e.err = !legal(f); e.data = arith(f, a, b);
    expq.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    rsp_ready = 1'b1;
    while ((expq.size() != 0 || busy) && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    chk("drain_left", expq.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({pfx, "_pe_opcode"}, pe_opcode, 32'd0);
    chk({pfx, "_pe_op1"}, pe_op1, 32'd0);
    chk({pfx, "_pe_op2"}, pe_op2, 32'd0);
    chk({pfx, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({pfx, "_rsp_data"}, rsp_data, 32'd0);
    chk({pfx, "_rsp_tag"}, {28'd0, rsp_tag}, 32'd0);
    chk({pfx, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          n;
    int          op_at;
    logic [31:0] op_val;
    logic [4:0]  f;

    rst = 1'b1; cmd_valid = 1'b0; cmd_func = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD 10+20 tag 3: opcode one edge after push, response three edges after push.
    cmd_valid = 1'b1; cmd_func = 5'd1; cmd_a = 32'd10; cmd_b = 32'd20; cmd_tag = 4'd3;
    @(posedge clk);
    expq.push_back('{func: 5'd1, data: 32'd30, tag: 4'd3, err: 1'b0});
    #1 cmd_valid = 1'b0;
    n = 0; op_at = -1; op_val = '0;
    while (!rsp_valid && n < 20) begin
      if (pe_opcode != 32'd0) begin op_at = n; op_val = pe_opcode; end
      @(posedge clk); #1; n++;
    end
    chk("add_latency", n, 32'd3);
    chk("add_issue_edge", op_at, 32'd1);
    chk("add_opcode", op_val, 32'h02100000);
    drain();

    push_cmd(5'd2, 32'd50, 32'd20, 4'd1, 1'b0);
    push_cmd(5'd3, 32'd10, 32'd5, 4'd2, 1'b0);
    drain();
    push_cmd(5'd2, 32'd0, 32'd1, 4'd4, 1'b0);
    push_cmd(5'd3, 32'h10000, 32'h10000, 4'd5, 1'b0);
    drain();
    push_cmd(5'd7, 32'd123, 32'd456, 4'd9, 1'b0);
    drain();

    // Backpressure: 1 in flight + 4 buffered, then the unit must refuse more.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(5'(1 + i % 3), 32'(100 * i + 7), 32'(i + 3), 4'(i + 10), 1'b0);
    chk("bp_cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_data", rsp_data, expq[0].data);
      chk("bp_hold_tag", {28'd0, rsp_tag}, {28'd0, expq[0].tag});
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    drain();

    // Randomized mix of legal and illegal commands under random backpressure.
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 7);
      if (n < 6) f = 5'(1 + n % 3);
      else       f = (n == 6) ? 5'd0 : 5'($urandom_range(4, 31));
      rsp_ready = ($urandom_range(0, 3) != 0);
      push_cmd(f, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    end
    drain();

    // Reset while the first command waits in WAIT with two more queued.
    push_cmd(5'd1, 32'd5, 32'd6, 4'd1, 1'b0);
    push_cmd(5'd2, 32'd9, 32'd4, 4'd2, 1'b0);
    push_cmd(5'd3, 32'd3, 32'd3, 4'd3, 1'b0);
    rst = 1'b1;
    expq.delete();
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    push_cmd(5'd1, 32'd1, 32'd1, 4'd6, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
